// File: rtl/id_ex_stage.sv
// Purpose : decode-to-execute pipeline register with mem/writeback operand forwarding feeding the ALU.
// Latency : decode fields reach execute outputs 1 cycle after the loading edge; forwarding is combinational (0 cycles).
// Backpressure: stall_e holds the register (refreshing operand data from forwarding); flush_e inserts a bubble and beats stall_e.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   stall_e, flush_e      hazard-unit hold / bubble controls
//   *_d                   decoded operands, indices and control from the decode stage
//   alu_result_m, rd_m, reg_write_m   memory-stage producer for forwarding
//   result_w, rd_w, reg_write_w       writeback-stage producer for forwarding
//   src_a_e, src_b_e, alu_control_e   ALU inputs
//   write_data_e          forwarded rs2 (store data)
//   remaining *_e         registered copies for branch resolution, EX/MEM and hazard unit
//   forward_a_e/_b_e      forwarding selects: 00 register file, 10 mem stage, 01 writeback stage

module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_e,
    input  logic                      flush_e,
    input  logic [DATA_WIDTH-1:0]     rd1_d,
    input  logic [DATA_WIDTH-1:0]     rd2_d,
    input  logic [DATA_WIDTH-1:0]     imm_ext_d,
    input  logic [DATA_WIDTH-1:0]     pc_d,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic [3:0]                alu_control_d,
    input  logic                      alu_src_a_d,
    input  logic                      alu_src_b_d,
    input  logic                      reg_write_d,
    input  logic                      mem_write_d,
    input  logic                      jump_d,
    input  logic                      branch_d,
    input  logic [1:0]                result_src_d,
    input  logic [2:0]                funct3_d,
    input  logic [DATA_WIDTH-1:0]     alu_result_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic [DATA_WIDTH-1:0]     result_w,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_w,
    output logic [DATA_WIDTH-1:0]     src_a_e,
    output logic [DATA_WIDTH-1:0]     src_b_e,
    output logic [3:0]                alu_control_e,
    output logic [DATA_WIDTH-1:0]     write_data_e,
    output logic [DATA_WIDTH-1:0]     imm_ext_e,
    output logic [DATA_WIDTH-1:0]     pc_e,
    output logic [DATA_WIDTH-1:0]     pc_plus4_e,
    output logic [REG_ADDR_WIDTH-1:0] rs1_e,
    output logic [REG_ADDR_WIDTH-1:0] rs2_e,
    output logic [REG_ADDR_WIDTH-1:0] rd_e,
    output logic                      reg_write_e,
    output logic                      mem_write_e,
    output logic                      jump_e,
    output logic                      branch_e,
    output logic [1:0]                result_src_e,
    output logic [2:0]                funct3_e,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e
);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Operand data and operand-source selects are kept internally; only the
    // muxed results leave the block.
    logic [DATA_WIDTH-1:0] rd1_e;
    logic [DATA_WIDTH-1:0] rd2_e;
    logic                  alu_src_a_e;
    logic                  alu_src_b_e;

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    // ------------------------------------------------------------------
    // Forwarding select. The mem stage holds the younger result, so it is
    // checked first. x0 is hardwired to zero and must never pick up a
    // bypassed value, even if some stage claims to write it.
    // ------------------------------------------------------------------
    always_comb begin
        forward_a_e = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) begin
            forward_a_e = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) begin
            forward_a_e = FWD_WB;
        end
    end

    always_comb begin
        forward_b_e = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) begin
            forward_b_e = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) begin
            forward_b_e = FWD_WB;
        end
    end

    always_comb begin
        fwd_a = rd1_e;
        case (forward_a_e)
            FWD_MEM: fwd_a = alu_result_m;
            FWD_WB:  fwd_a = result_w;
            default: fwd_a = rd1_e;
        endcase
    end

    always_comb begin
        fwd_b = rd2_e;
        case (forward_b_e)
            FWD_MEM: fwd_b = alu_result_m;
            FWD_WB:  fwd_b = result_w;
            default: fwd_b = rd2_e;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU operand muxing. Store data always takes the forwarded rs2, even
    // when the ALU B input is the immediate (address generation).
    // ------------------------------------------------------------------
    always_comb begin
        src_a_e      = alu_src_a_e ? pc_e : fwd_a;
        src_b_e      = alu_src_b_e ? imm_ext_e : fwd_b;
        write_data_e = fwd_b;
    end

    // ------------------------------------------------------------------
    // Pipeline register. Priority: flush > stall > load.
    // During a stall the operand data fields are refreshed with the
    // forwarded values: a producer may retire out of writeback while we
    // wait, and without this its result would be lost (the register file
    // copy we captured at decode is stale).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            alu_control_e <= '0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            result_src_e  <= '0;
            funct3_e      <= '0;
        end else if (flush_e) begin
            // Bubble: an all-zero entry is an add of x0+x0 with no side effects.
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            alu_control_e <= '0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            result_src_e  <= '0;
            funct3_e      <= '0;
        end else if (stall_e) begin
            rd1_e <= fwd_a;
            rd2_e <= fwd_b;
        end else begin
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            imm_ext_e     <= imm_ext_d;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_plus4_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            rd_e          <= rd_d;
            alu_control_e <= alu_control_d;
            alu_src_a_e   <= alu_src_a_d;
            alu_src_b_e   <= alu_src_b_d;
            reg_write_e   <= reg_write_d;
            mem_write_e   <= mem_write_d;
            jump_e        <= jump_d;
            branch_e      <= branch_d;
            result_src_e  <= result_src_d;
            funct3_e      <= funct3_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : self-checking bench for id_ex_stage (load, forwarding, x0 guard, stall capture, flush, reset).
// Latency : expectations are queued when stimulus is driven and compared one cycle later (or #1 for combinational paths).
// Backpressure: stall_e / flush_e driven directly by the scenarios.

module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_e, flush_e;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [3:0]  alu_control_d;
    logic        alu_src_a_d, alu_src_b_d;
    logic        reg_write_d, mem_write_d, jump_d, branch_d;
    logic [1:0]  result_src_d;
    logic [2:0]  funct3_d;
    logic [31:0] alu_result_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;

    logic [31:0] src_a_e, src_b_e, write_data_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [3:0]  alu_control_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        reg_write_e, mem_write_e, jump_e, branch_e;
    logic [1:0]  result_src_e;
    logic [2:0]  funct3_e;
    logic [1:0]  forward_a_e, forward_b_e;

    typedef struct packed {
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] wd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        j;
        logic        b;
        logic [1:0]  rsrc;
        logic [2:0]  f3;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } obs_t;

    obs_t sb[$];
    obs_t got, exp_v, e;
    int   n_run  = 0;
    int   n_fail = 0;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
        .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
        .result_src_d(result_src_d), .funct3_d(funct3_d),
        .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e), .write_data_e(write_data_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
        .result_src_e(result_src_e), .funct3_e(funct3_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.src_a = src_a_e;      o.src_b = src_b_e;   o.wd  = write_data_e;
        o.imm   = imm_ext_e;    o.pc    = pc_e;      o.pc4 = pc_plus4_e;
        o.alu   = alu_control_e;
        o.rs1   = rs1_e;        o.rs2   = rs2_e;     o.rd  = rd_e;
        o.rw    = reg_write_e;  o.mw    = mem_write_e;
        o.j     = jump_e;       o.b     = branch_e;
        o.rsrc  = result_src_e; o.f3    = funct3_e;
        o.fa    = forward_a_e;  o.fb    = forward_b_e;
        return o;
    endfunction

    task automatic clear_inputs();
        stall_e = 0; flush_e = 0;
        rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0; pc_plus4_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alu_control_d = 0;
        alu_src_a_d = 0; alu_src_b_d = 0;
        reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0;
        result_src_d = 0; funct3_d = 0;
        alu_result_m = 0; rd_m = 0; reg_write_m = 0;
        result_w = 0; rd_w = 0; reg_write_w = 0;
    endtask

    task automatic rand_inputs();
        stall_e = 1'($urandom); flush_e = 1'($urandom);
        rd1_d = $urandom; rd2_d = $urandom; imm_ext_d = $urandom;
        pc_d = $urandom; pc_plus4_d = $urandom;
        rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
        alu_control_d = 4'($urandom);
        alu_src_a_d = 1'($urandom); alu_src_b_d = 1'($urandom);
        reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
        jump_d = 1'($urandom); branch_d = 1'($urandom);
        result_src_d = 2'($urandom); funct3_d = 3'($urandom);
        alu_result_m = $urandom; rd_m = 5'($urandom); reg_write_m = 1'($urandom);
        result_w = $urandom; rd_w = 5'($urandom); reg_write_w = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 0;
        rand_inputs();
        sb.push_back('0);
        repeat (3) @(posedge clk);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %h exp %h", got, exp_v); end
        clear_inputs();
        rst_n = 1;
        sb.push_back('0);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_release: got %h exp %h", got, exp_v); end
        sb.push_back('0);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_first_load: got %h exp %h", got, exp_v); end
    endtask

    task automatic test_plain_load();
        clear_inputs();
        rd1_d = 5; rd2_d = 7; rs1_d = 1; rs2_d = 2; rd_d = 9;
        alu_control_d = 4'b1000; imm_ext_d = 32'h123; pc_d = 32'h100; pc_plus4_d = 32'h104;
        reg_write_d = 1; result_src_d = 2'b01; funct3_d = 3'b010;
        rd_m = 5'd20; reg_write_m = 1; alu_result_m = 32'hDEAD;
        rd_w = 5'd21; reg_write_w = 1; result_w = 32'hBEEF;
        e = '0;
        e.src_a = 5; e.src_b = 7; e.wd = 7; e.imm = 32'h123; e.pc = 32'h100; e.pc4 = 32'h104;
        e.alu = 4'b1000; e.rs1 = 1; e.rs2 = 2; e.rd = 9; e.rw = 1; e.rsrc = 2'b01; e.f3 = 3'b010;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL plain_load: got %h exp %h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        // first: AUIPC-style, src_a from PC, src_b from immediate
        rd1_d = 32'h1111; rd2_d = 32'h2222; rs1_d = 10; rs2_d = 11; rd_d = 12;
        alu_src_a_d = 1; alu_src_b_d = 1; imm_ext_d = 32'h0000_5000;
        pc_d = 32'h400; pc_plus4_d = 32'h404; reg_write_d = 1; jump_d = 1; result_src_d = 2'b10;
        e = '0;
        e.src_a = 32'h400; e.src_b = 32'h5000; e.wd = 32'h2222; e.imm = 32'h5000;
        e.pc = 32'h400; e.pc4 = 32'h404; e.rs1 = 10; e.rs2 = 11; e.rd = 12;
        e.rw = 1; e.j = 1; e.rsrc = 2'b10;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", got, exp_v); end
        // second: branch with register operands
        rd1_d = 32'hA0; rd2_d = 32'hB0; rs1_d = 13; rs2_d = 14; rd_d = 0;
        alu_src_a_d = 0; alu_src_b_d = 0; imm_ext_d = 32'hFFFF_FFFC; alu_control_d = 4'b0001;
        pc_d = 32'h408; pc_plus4_d = 32'h40C; reg_write_d = 0; jump_d = 0; branch_d = 1;
        result_src_d = 0; funct3_d = 3'b001;
        e = '0;
        e.src_a = 32'hA0; e.src_b = 32'hB0; e.wd = 32'hB0; e.imm = 32'hFFFF_FFFC;
        e.pc = 32'h408; e.pc4 = 32'h40C; e.alu = 4'b0001; e.rs1 = 13; e.rs2 = 14;
        e.b = 1; e.f3 = 3'b001;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", got, exp_v); end
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        rs1_d = 3; rs2_d = 3; rd1_d = 32'hAAA; rd2_d = 32'hBBB; rd_d = 8;
        rd_m = 3; reg_write_m = 1; alu_result_m = 32'h11;
        rd_w = 3; reg_write_w = 1; result_w = 32'h22;
        e = '0;
        e.src_a = 32'h11; e.src_b = 32'h11; e.wd = 32'h11;
        e.rs1 = 3; e.rs2 = 3; e.rd = 8; e.fa = 2'b10; e.fb = 2'b10;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL fwd_mem_over_wb: got %h exp %h", got, exp_v); end
        reg_write_m = 0;
        e.src_a = 32'h22; e.src_b = 32'h22; e.wd = 32'h22; e.fa = 2'b01; e.fb = 2'b01;
        sb.push_back(e);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL fwd_wb: got %h exp %h", got, exp_v); end
        reg_write_w = 0;
        e.src_a = 32'hAAA; e.src_b = 32'hBBB; e.wd = 32'hBBB; e.fa = 2'b00; e.fb = 2'b00;
        sb.push_back(e);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL fwd_none: got %h exp %h", got, exp_v); end
    endtask

    task automatic test_x0_and_imm();
        clear_inputs();
        rs1_d = 0; rs2_d = 0; rd1_d = 32'h66; rd2_d = 32'h77;
        rd_m = 0; reg_write_m = 1; alu_result_m = 32'hFF;
        rd_w = 0; reg_write_w = 1; result_w = 32'hEE;
        e = '0;
        e.src_a = 32'h66; e.src_b = 32'h77; e.wd = 32'h77;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL x0_guard: got %h exp %h", got, exp_v); end
        // store-like: B from immediate, store data still forwarded rs2
        rs1_d = 6; rs2_d = 2; alu_src_b_d = 1; imm_ext_d = 32'hFFFF_FFF0; mem_write_d = 1;
        rd_w = 2; reg_write_w = 1; result_w = 32'h1234;
        e = '0;
        e.src_a = 32'h66; e.src_b = 32'hFFFF_FFF0; e.wd = 32'h1234; e.imm = 32'hFFFF_FFF0;
        e.rs1 = 6; e.rs2 = 2; e.mw = 1; e.fb = 2'b01;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL imm_store_data: got %h exp %h", got, exp_v); end
    endtask

    task automatic test_stall();
        clear_inputs();
        rs1_d = 4; rd1_d = 32'h40; rs2_d = 7; rd2_d = 32'h70; rd_d = 11;
        reg_write_d = 1; branch_d = 1; funct3_d = 3'b101; alu_control_d = 4'b0011;
        imm_ext_d = 32'h8; pc_d = 32'h200; pc_plus4_d = 32'h204; result_src_d = 2'b10;
        rd_w = 4; reg_write_w = 1; result_w = 32'h99;
        e = '0;
        e.src_a = 32'h99; e.src_b = 32'h70; e.wd = 32'h70; e.imm = 32'h8;
        e.pc = 32'h200; e.pc4 = 32'h204; e.alu = 4'b0011; e.rs1 = 4; e.rs2 = 7; e.rd = 11;
        e.rw = 1; e.b = 1; e.rsrc = 2'b10; e.f3 = 3'b101; e.fa = 2'b01;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL stall_setup: got %h exp %h", got, exp_v); end
        // stall with different decode contents that must not be captured
        stall_e = 1;
        rs1_d = 9; rd1_d = 32'h5555; rs2_d = 8; rd2_d = 32'h6666; rd_d = 1;
        reg_write_d = 0; branch_d = 0; jump_d = 1; mem_write_d = 1; funct3_d = 3'b000;
        alu_control_d = 4'b1111; imm_ext_d = 32'hCAFE; pc_d = 32'h900; pc_plus4_d = 32'h904;
        result_src_d = 2'b01; alu_src_a_d = 1; alu_src_b_d = 1;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL stall_cycle1: got %h exp %h", got, exp_v); end
        // producer has left writeback: value must come from the captured copy
        rd_w = 0; result_w = 32'h0;
        e.fa = 2'b00;
        sb.push_back(e);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL stall_captured: got %h exp %h", got, exp_v); end
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL stall_cycle2: got %h exp %h", got, exp_v); end
        stall_e = 0;
    endtask

    task automatic test_flush_during_stall();
        clear_inputs();
        rs1_d = 5; rs2_d = 6; rd_d = 7; rd1_d = 32'h50; rd2_d = 32'h60;
        reg_write_d = 1; mem_write_d = 1; jump_d = 1; alu_control_d = 4'b0111;
        imm_ext_d = 32'h44; pc_d = 32'h300; pc_plus4_d = 32'h304; funct3_d = 3'b010;
        e = '0;
        e.src_a = 32'h50; e.src_b = 32'h60; e.wd = 32'h60; e.imm = 32'h44;
        e.pc = 32'h300; e.pc4 = 32'h304; e.alu = 4'b0111; e.rs1 = 5; e.rs2 = 6; e.rd = 7;
        e.rw = 1; e.mw = 1; e.j = 1; e.f3 = 3'b010;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL flush_setup: got %h exp %h", got, exp_v); end
        stall_e = 1; flush_e = 1;
        rd_m = 5; reg_write_m = 1; alu_result_m = 32'h1;
        sb.push_back('0);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL flush_wins: got %h exp %h", got, exp_v); end
        stall_e = 0; flush_e = 0;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        rs1_d = 1; rs2_d = 2; rd_d = 3; rd1_d = 32'h10; rd2_d = 32'h20;
        reg_write_d = 1; alu_control_d = 4'b0010; pc_d = 32'h500; pc_plus4_d = 32'h504;
        e = '0;
        e.src_a = 32'h10; e.src_b = 32'h20; e.wd = 32'h20; e.pc = 32'h500; e.pc4 = 32'h504;
        e.alu = 4'b0010; e.rs1 = 1; e.rs2 = 2; e.rd = 3; e.rw = 1;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL async_setup: got %h exp %h", got, exp_v); end
        #2;
        rst_n = 0;
        sb.push_back('0);
        #1;
        got = sample(); exp_v = sb.pop_front(); n_run++;
        if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_clear: got %h exp %h", got, exp_v); end
        @(posedge clk); #2;
        clear_inputs();
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_plain_load();
        test_back_to_back();
        test_forward_priority();
        test_x0_and_imm();
        test_stall();
        test_flush_during_stall();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32I core.
- Captures decoded operands and control from decode, then resolves data forwarding from the memory and writeback stages.
- Drives SrcA, SrcB and ALUControl directly into the ALU.
- Also exports the forwarded rs2 value, used as store data, plus the execute-stage control bundle consumed by branch resolution and the EX/MEM register.

Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_e  in  1  hold the execute register (from hazard unit).
- flush_e  in  1  replace the execute register with a bubble (from hazard unit).
- rd1_d, rd2_d  in  DATA_WIDTH  register-file read data.
- imm_ext_d  in  DATA_WIDTH  sign-extended immediate.
- pc_d, pc_plus4_d  in  DATA_WIDTH  instruction PC and PC+4.
- rs1_d, rs2_d, rd_d  in  REG_ADDR_WIDTH  source and destination indices.
- alu_control_d  in  4  ALU opcode, same encoding as the ALU.
- alu_src_a_d  in  1  0 selects rs1, 1 selects PC (AUIPC).
- alu_src_b_d  in  1  0 selects rs2, 1 selects immediate.
- reg_write_d, mem_write_d, jump_d, branch_d  in  1  control.
- result_src_d  in  2  writeback source select.
- funct3_d  in  3  branch/load/store subtype.
- alu_result_m  in  DATA_WIDTH  memory-stage ALU result.
- rd_m  in  REG_ADDR_WIDTH  memory-stage destination.
- reg_write_m  in  1  memory-stage write enable.
- result_w  in  DATA_WIDTH  writeback-stage result.
- rd_w  in  REG_ADDR_WIDTH  writeback-stage destination.
- reg_write_w  in  1  writeback-stage write enable.
- src_a_e, src_b_e  out  DATA_WIDTH  ALU operands.
- alu_control_e  out  4  ALU opcode.
- write_data_e  out  DATA_WIDTH  forwarded rs2, used as store data.
- imm_ext_e, pc_e, pc_plus4_e  out  DATA_WIDTH  registered copies.
- rs1_e, rs2_e, rd_e  out  REG_ADDR_WIDTH  registered indices, fed to the hazard unit.
- reg_write_e, mem_write_e, jump_e, branch_e  out  1  registered control.
- result_src_e  out  2  registered control.
- funct3_e  out  3  registered control.
- forward_a_e, forward_b_e  out  2  forwarding select: 00 register, 10 mem stage, 01 writeback stage.

Behaviour:
- Reset: on rst_n low, asynchronously clear every register to 0. All registered outputs read 0, and the combinational outputs follow (src_a_e = src_b_e = 0). Release is synchronous to the next clk edge.
- Update priority at each rising edge: flush_e > stall_e > load.
  - Load: capture all *_d inputs.
  - Flush: bubble. Every field becomes 0; reg_write_e, mem_write_e, jump_e and branch_e are 0; alu_control_e is 0000 (add).
  - Stall: indices, control, imm and PC hold their values. The stored rd1/rd2 fields are overwritten with the currently forwarded A/B register values, so a producer leaving writeback during the stall is not lost.
  - Simultaneous flush_e and stall_e: flush wins.
- Forwarding (combinational, from the registered rs1_e/rs2_e):
  - Mem stage, sel 10: reg_write_m=1, rd_m != 0, and rd_m == rs_e.
  - Writeback stage, sel 01: otherwise, if reg_write_w=1, rd_w != 0, and rd_w == rs_e.
  - Register, sel 00: otherwise.
  - Mem beats writeback when both match.
  - rs = x0 never forwards.
- Operand muxing:
  - fwd_a / fwd_b are the forwarded rs1 / rs2 values.
  - src_a_e = alu_src_a_e ? pc_e : fwd_a.
  - src_b_e = alu_src_b_e ? imm_ext_e : fwd_b.
  - write_data_e = fwd_b always, independent of alu_src_b_e.
- Latency: decode values appear on execute outputs 1 cycle after the loading edge. Forwarding adds 0 cycles.
- Load-use hazards are detected outside this block. This block only provides rs1_e, rs2_e, rd_e and result_src_e.

Test Plan:
1. Reset: hold rst_n=0 with random inputs, then release. All outputs are 0 and forward_a_e = forward_b_e = 00. Assert rst_n low mid-run: outputs clear immediately, without waiting for a clock edge.
2. Plain load: rd1_d=5, rd2_d=7, rs1_d=1, rs2_d=2, alu_src_b_d=0, alu_control_d=1000, no matching M/W. Next cycle: src_a_e=5, src_b_e=7, alu_control_e=1000, forward selects 00.
3. Forward priority: rs1_e=3; rd_m=3, reg_write_m=1, alu_result_m=0x11; rd_w=3, reg_write_w=1, result_w=0x22. Expect src_a_e=0x11, forward_a_e=10. Then drop reg_write_m: src_a_e=0x22, forward_a_e=01.
4. x0 guard and immediate: rs2_e=0, rd_m=0, reg_write_m=1, alu_result_m=0xFF. Expect forward_b_e=00 and the register value is used. With alu_src_b_e=1 and imm_ext_e=0xFFFFFFF0: src_b_e=0xFFFFFFF0, while write_data_e stays at the forwarded rs2.
5. Stall capture: rs1_e=4 forwarded from W with result_w=0x99; assert stall_e for 2 cycles. In cycle 2, W no longer matches (rd_w=0). src_a_e stays 0x99 and all control and indices hold.
6. Flush during stall: stall_e=1 and flush_e=1 with reg_write_e=1 and mem_write_e=1 in the register. Next cycle: bubble, all control 0, alu_control_e=0000, src_a_e=src_b_e=0.
